// File: rtl/hbridge_guard_if.sv
// Request/response bundle between a motor driver and its H-bridge guard.
// The master side issues direction/enable requests; the slave side owns the guarded pins.
interface hbridge_guard_if #(
  parameter int unsigned CHG_W = 8
);
  logic             req_a;
  logic             req_b;
  logic             req_en;
  logic             estop;
  logic             out_a;
  logic             out_b;
  logic             out_en;
  logic             busy;
  logic             fault;
  logic [CHG_W-1:0] chg_count;

  modport master (
    output req_a, req_b, req_en, estop,
    input  out_a, out_b, out_en, busy, fault, chg_count
  );

  modport slave (
    input  req_a, req_b, req_en, estop,
    output out_a, out_b, out_en, busy, fault, chg_count
  );
endinterface

// File: rtl/hbridge_guard.sv
// H-bridge protection stage: forces a timed all-off dead interval whenever drive is left,
// rejects the both-high request and honours an emergency stop.
module hbridge_guard #(
  parameter int unsigned DEAD_CYCLES = 50000,
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned CHG_W       = 8
) (
  input logic           clk,
  input logic           rst_n,
  hbridge_guard_if.slave bus
);

  typedef enum logic [1:0] {StCoast, StDrive, StDead} state_e;

  state_e           state_q, state_d;
  logic             dir_fwd_q, dir_fwd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CHG_W-1:0] chg_q, chg_d;
  logic             fault_q, fault_d;
  logic             out_a_q, out_a_d;
  logic             out_b_q, out_b_d;
  logic             out_en_q, out_en_d;
  logic             busy_q, busy_d;

  logic req_fwd, req_rev, keep_drive;

  // The illegal 11 code decodes to neither direction, so it behaves as STOP.
  assign req_fwd    = bus.req_a & ~bus.req_b;
  assign req_rev    = ~bus.req_a & bus.req_b;
  assign keep_drive = ~bus.estop & (dir_fwd_q ? req_fwd : req_rev);

  always_comb begin
    state_d   = state_q;
    dir_fwd_d = dir_fwd_q;
    cnt_d     = cnt_q;
    chg_d     = chg_q;
    fault_d   = fault_q | (bus.req_a & bus.req_b);
    out_a_d   = 1'b0;
    out_b_d   = 1'b0;
    out_en_d  = 1'b0;
    busy_d    = 1'b0;

    unique case (state_q)
      StCoast: begin
        if ((req_fwd | req_rev) & ~bus.estop) begin
          state_d   = StDrive;
          dir_fwd_d = req_fwd;
          out_a_d   = req_fwd;
          out_b_d   = req_rev;
          out_en_d  = bus.req_en;
        end
      end
      StDrive: begin
        if (keep_drive) begin
          out_a_d  = dir_fwd_q;
          out_b_d  = ~dir_fwd_q;
          out_en_d = bus.req_en;
        end else begin
          state_d = StDead;
          cnt_d   = CNT_W'(DEAD_CYCLES - 1);
          busy_d  = 1'b1;
          if (chg_q != '1) begin
            chg_d = chg_q + CHG_W'(1);
          end
        end
      end
      StDead: begin
        // Requests and estop are deliberately ignored so the interval is never shortened.
        if (cnt_q == '0) begin
          state_d = StCoast;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = StCoast;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StCoast;
      dir_fwd_q <= 1'b0;
      cnt_q     <= '0;
      chg_q     <= '0;
      fault_q   <= 1'b0;
      out_a_q   <= 1'b0;
      out_b_q   <= 1'b0;
      out_en_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_fwd_q <= dir_fwd_d;
      cnt_q     <= cnt_d;
      chg_q     <= chg_d;
      fault_q   <= fault_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      out_en_q  <= out_en_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_en    = out_en_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;
  assign bus.chg_count = chg_q;

endmodule

// File: tb/tb_hbridge_guard.sv
// Self-checking bench for hbridge_guard: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_hbridge_guard;
  localparam int unsigned DEAD  = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CHG_W = 2;
  localparam int          CHG_MAX = (1 << CHG_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  hbridge_guard_if #(.CHG_W(CHG_W)) bus ();

  hbridge_guard #(
    .DEAD_CYCLES(DEAD),
    .CNT_W      (CNT_W),
    .CHG_W      (CHG_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: drive direction (0 none, 1 fwd, 2 rev) plus remaining dead cycles.
  int   m_drive, m_dead, m_chg;
  logic m_fault, m_a, m_b, m_en, m_busy;

  task automatic model_step();
    int req;
    req = (bus.req_a && !bus.req_b) ? 1 : ((!bus.req_a && bus.req_b) ? 2 : 0);
    if (!rst_n) begin
      m_drive = 0; m_dead = 0; m_chg = 0; m_fault = 0;
      m_a = 0; m_b = 0; m_en = 0; m_busy = 0;
      return;
    end
    if (bus.req_a && bus.req_b) m_fault = 1;
    m_a = 0; m_b = 0; m_en = 0; m_busy = 0;
    if (m_dead > 0) begin
      m_dead--;
      m_busy = (m_dead > 0);
    end else if (m_drive != 0 && (bus.estop || req != m_drive)) begin
      m_drive = 0;
      m_dead  = DEAD;
      m_busy  = 1;
      if (m_chg < CHG_MAX) m_chg++;
    end else begin
      if (m_drive == 0 && req != 0 && !bus.estop) m_drive = req;
      if (m_drive != 0) begin
        m_a  = (m_drive == 1);
        m_b  = (m_drive == 2);
        m_en = bus.req_en;
      end
    end
  endtask

  function automatic logic [6:0] exp_vec();
    return {m_a, m_b, m_en, m_busy, m_fault, CHG_W'(m_chg)};
  endfunction

  function automatic logic [6:0] act_vec();
    return {bus.out_a, bus.out_b, bus.out_en, bus.busy, bus.fault, bus.chg_count};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic a, input logic b);
    bus.req_a = a;
    bus.req_b = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set_req(1, 0); bus.req_en = 1'b1; bus.estop = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (act_vec() !== 7'b0) begin
      n_fail++; $display("FAIL reset_hold: got %b want 0000000", act_vec());
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({bus.out_a, bus.out_en, bus.out_b, bus.busy} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_release a/en/b/busy: got %b want 1100",
                         {bus.out_a, bus.out_en, bus.out_b, bus.busy});
    end
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model: got %b want %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_reversal();
    do_reset();
    set_req(1, 0); bus.req_en = 1'b1; bus.estop = 1'b0;
    repeat (3) tick();
    set_req(0, 1);
    for (int i = 0; i < DEAD; i++) begin
      tick();
      n_checks++;
      if ({bus.out_a, bus.out_b, bus.out_en, bus.busy} !== 4'b0001) begin
        n_fail++; $display("FAIL rev_dead[%0d]: got %b want 0001", i,
                           {bus.out_a, bus.out_b, bus.out_en, bus.busy});
      end
    end
    tick();
    n_checks++;
    if ({bus.out_a, bus.out_b, bus.out_en, bus.busy} !== 4'b0000) begin
      n_fail++; $display("FAIL rev_coast: got %b want 0000",
                         {bus.out_a, bus.out_b, bus.out_en, bus.busy});
    end
    tick();
    n_checks++;
    if ({bus.out_a, bus.out_b, bus.out_en, bus.busy} !== 4'b0110) begin
      n_fail++; $display("FAIL rev_drive: got %b want 0110",
                         {bus.out_a, bus.out_b, bus.out_en, bus.busy});
    end
    n_checks++;
    if (bus.chg_count !== CHG_W'(1)) begin
      n_fail++; $display("FAIL rev_chg: got %0d want 1", bus.chg_count);
    end
  endtask

  task automatic test_pwm();
    logic [9:0] pat;
    pat = 10'b1110011100;
    do_reset();
    set_req(1, 0); bus.req_en = 1'b1; bus.estop = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.req_en = pat[9-i];
      tick();
      n_checks++;
      if ({bus.out_a, bus.out_en, bus.busy} !== {1'b1, pat[9-i], 1'b0}) begin
        n_fail++; $display("FAIL pwm[%0d] a/en/busy: got %b want %b", i,
                           {bus.out_a, bus.out_en, bus.busy}, {1'b1, pat[9-i], 1'b0});
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    set_req(1, 0); bus.req_en = 1'b1; bus.estop = 1'b0;
    repeat (2) tick();
    set_req(1, 1);
    tick();
    n_checks++;
    if ({bus.out_a, bus.out_b, bus.busy, bus.fault} !== 4'b0011) begin
      n_fail++; $display("FAIL illegal_exit a/b/busy/fault: got %b want 0011",
                         {bus.out_a, bus.out_b, bus.busy, bus.fault});
    end
    set_req(1, 0);
    repeat (DEAD + 1) begin
      tick();
      n_checks++;
      if ((bus.out_a & bus.out_b) !== 1'b0 || act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL illegal_seq: got %b want %b", act_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({bus.out_a, bus.busy, bus.fault} !== 3'b101) begin
      n_fail++; $display("FAIL illegal_resume a/busy/fault: got %b want 101",
                         {bus.out_a, bus.busy, bus.fault});
    end
  endtask

  task automatic test_estop();
    do_reset();
    set_req(1, 0); bus.req_en = 1'b1; bus.estop = 1'b0;
    repeat (2) tick();
    bus.estop = 1'b1;
    tick();
    n_checks++;
    if ({bus.out_a, bus.out_b, bus.out_en, bus.busy} !== 4'b0001) begin
      n_fail++; $display("FAIL estop_enter: got %b want 0001",
                         {bus.out_a, bus.out_b, bus.out_en, bus.busy});
    end
    repeat (DEAD + 4) tick();
    n_checks++;
    if ({bus.out_a, bus.out_b, bus.out_en, bus.busy} !== 4'b0000) begin
      n_fail++; $display("FAIL estop_hold: got %b want 0000",
                         {bus.out_a, bus.out_b, bus.out_en, bus.busy});
    end
    bus.estop = 1'b0;
    tick();
    n_checks++;
    if ({bus.out_a, bus.out_en, bus.busy} !== 3'b110) begin
      n_fail++; $display("FAIL estop_resume a/en/busy: got %b want 110",
                         {bus.out_a, bus.out_en, bus.busy});
    end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.req_en = 1'b1; bus.estop = 1'b0;
    repeat (5) begin
      set_req(1, 0); tick();
      set_req(0, 0); repeat (DEAD + 1) tick();
    end
    n_checks++;
    if (bus.chg_count !== CHG_W'(CHG_MAX)) begin
      n_fail++; $display("FAIL chg_saturate: got %0d want %0d", bus.chg_count, CHG_MAX);
    end
    set_req(0, 1); tick();
    set_req(0, 0); repeat (4) tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_dead_busy: got %b want 1", bus.busy);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (act_vec() !== 7'b0) begin
      n_fail++; $display("FAIL mid_dead_reset: got %b want 0000000", act_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5, 0) == 0) begin
        case ($urandom_range(9, 0))
          0:       set_req(1, 1);
          1, 2:    set_req(0, 0);
          3, 4, 5: set_req(0, 1);
          default: set_req(1, 0);
        endcase
      end
      if ($urandom_range(24, 0) == 0) bus.estop = ~bus.estop;
      bus.req_en = 1'($urandom_range(1, 0));
      rst_n = ($urandom_range(199, 0) != 0);
      tick();
      n_checks++;
      if ((bus.out_a & bus.out_b) !== 1'b0 || act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %b want %b", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.req_en = 1'b0; bus.estop = 1'b0;
    test_reset();
    test_reversal();
    test_pwm();
    test_illegal();
    test_estop();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
